lutram_checker: RTL and testbench

Self-checking scoreboard that sits directly downstream of the LUTRAM primitive test harnesses (RAM64X1D and siblings). It observes the stimulus applied to the DUT (write enable, write address, write data, read address) together with the DUT's SPO/DPO outputs, keeps a shadow model of the memory, and counts read-back mismatches. It reports a registered pass/fail verdict for LEDs or ILA capture, so results are checked on silicon rather than by inspecting waveforms.

---
 rtl/lutram_test_pkg.sv | 31 +++
 rtl/lutram_shadow.sv | 42 ++++
 rtl/lutram_checker.sv | 108 ++++++++++
 tb/tb_lutram_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lutram_test_pkg.sv
// Purpose: shared encodings for the LUTRAM primitive test harnesses and their checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: stimulus phase encoding, default address widths per primitive,
//           status_o bit positions and the checker FSM state type.
package lutram_test_pkg;

  // Phases walked by the stimulus generator; FINISH drives the checker's done_i.
  typedef enum logic [2:0] {
    PH_INITIAL = 3'd0,
    PH_CLEAR   = 3'd1,
    PH_WRITE   = 3'd2,
    PH_READ    = 3'd3,
    PH_FINISH  = 3'd4
  } phase_e;

  // Default address widths per primitive family.
  localparam int A_WIDTH_RAM32  = 5;
  localparam int A_WIDTH_RAM64  = 6;
  localparam int A_WIDTH_RAM128 = 7;

  // status_o = {done, pass}
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_PASS_BIT = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } chk_state_e;

endpackage

// File: rtl/lutram_shadow.sv
// Purpose: shadow copy of the LUTRAM under test: one data bit plus one known bit per word.
// Latency: reads are combinational; writes take effect after the clock edge.
// Backpressure: none; a write is accepted on every cycle we_i is high.
// Ports: clk_i/rst_n_i clock and async active-low reset (clears the known mask only),
//        we_i/wa_i/d_i write port, ra0_i/ra1_i read addresses, q*_o data, k*_o known flags.
module lutram_shadow #(
  parameter int A_WIDTH = 6
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] wa_i,
  input  logic               d_i,
  input  logic [A_WIDTH-1:0] ra0_i,
  input  logic [A_WIDTH-1:0] ra1_i,
  output logic               q0_o,
  output logic               k0_o,
  output logic               q1_o,
  output logic               k1_o
);

  localparam int DEPTH = 1 << A_WIDTH;

  logic [DEPTH-1:0] r_data;
  logic [DEPTH-1:0] r_known;

  // Data bits are meaningless until their known bit is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) r_data[wa_i] <= d_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  r_known       <= '0;
    else if (we_i) r_known[wa_i] <= 1'b1;
  end

  assign q0_o = r_data[ra0_i];
  assign k0_o = r_known[ra0_i];
  assign q1_o = r_data[ra1_i];
  assign k1_o = r_known[ra1_i];

endmodule

// File: rtl/lutram_checker.sv
// Purpose: scoreboard comparing LUTRAM SPO/DPO against a shadow model; counts mismatches, latches first error.
// Latency: counters and first-error fields update one edge after the sample; status_o one edge later still.
// Backpressure: none; observes every valid_i cycle, ignores all stimulus once done.
// Ports: clk_i, rst_n_i; stimulus valid_i/we_i/a_i/dpra_i/d_i; DUT outputs spo_i/dpo_i; done_i;
//        results spo_err_cnt_o, dpo_err_cnt_o, first_err_addr_o/port_o/vld_o, status_o = {done, pass}.
module lutram_checker
  import lutram_test_pkg::*;
#(
  parameter int A_WIDTH   = 6,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 valid_i,
  input  logic                 we_i,
  input  logic [A_WIDTH-1:0]   a_i,
  input  logic [A_WIDTH-1:0]   dpra_i,
  input  logic                 d_i,
  input  logic                 spo_i,
  input  logic                 dpo_i,
  input  logic                 done_i,
  output logic [CNT_WIDTH-1:0] spo_err_cnt_o,
  output logic [CNT_WIDTH-1:0] dpo_err_cnt_o,
  output logic [A_WIDTH-1:0]   first_err_addr_o,
  output logic                 first_err_port_o,
  output logic                 first_err_vld_o,
  output logic [1:0]           status_o
);

  chk_state_e           r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_spo_cnt, r_dpo_cnt;
  logic [A_WIDTH-1:0]   r_first_addr;
  logic                 r_first_port, r_first_vld;
  logic [1:0]           r_status, w_status_nxt;

  logic w_active, w_spo_exp, w_spo_known, w_dpo_exp, w_dpo_known;
  logic w_spo_mis, w_dpo_mis;

  assign w_active = (r_state == ST_RUN) && valid_i;

  // Port 0 serves both the write and the SPO read; reads see pre-edge contents.
  lutram_shadow #(.A_WIDTH(A_WIDTH)) u_shadow (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (w_active && we_i),
    .wa_i    (a_i),
    .d_i     (d_i),
    .ra0_i   (a_i),
    .ra1_i   (dpra_i),
    .q0_o    (w_spo_exp),
    .k0_o    (w_spo_known),
    .q1_o    (w_dpo_exp),
    .k1_o    (w_dpo_known)
  );

  // Case inequality so an undriven/X output at a known address is a mismatch.
  assign w_spo_mis = w_active && w_spo_known && (spo_i !== w_spo_exp);
  assign w_dpo_mis = w_active && w_dpo_known && (dpo_i !== w_dpo_exp);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (done_i) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Verdict is computed from already-registered results, so it includes errors
  // sampled on the same edge as done_i.
  always_comb begin
    w_status_nxt = 2'b00;
    w_status_nxt[STATUS_DONE_BIT] = (r_state == ST_DONE);
    w_status_nxt[STATUS_PASS_BIT] = (r_state == ST_DONE) && (r_spo_cnt == '0) &&
                                    (r_dpo_cnt == '0) && !r_first_vld;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_RUN;
      r_spo_cnt    <= '0;
      r_dpo_cnt    <= '0;
      r_first_addr <= '0;
      r_first_port <= 1'b0;
      r_first_vld  <= 1'b0;
      r_status     <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
      if (w_spo_mis && (r_spo_cnt != '1)) r_spo_cnt <= r_spo_cnt + 1'b1;
      if (w_dpo_mis && (r_dpo_cnt != '1)) r_dpo_cnt <= r_dpo_cnt + 1'b1;
      // SPO takes priority when both ports miss on the same edge.
      if (!r_first_vld && (w_spo_mis || w_dpo_mis)) begin
        r_first_vld  <= 1'b1;
        r_first_port <= !w_spo_mis;
        r_first_addr <= w_spo_mis ? a_i : dpra_i;
      end
    end
  end

  assign spo_err_cnt_o    = r_spo_cnt;
  assign dpo_err_cnt_o    = r_dpo_cnt;
  assign first_err_addr_o = r_first_addr;
  assign first_err_port_o = r_first_port;
  assign first_err_vld_o  = r_first_vld;
  assign status_o         = r_status;

endmodule

// File: tb/tb_lutram_checker.sv
module tb_lutram_checker;

  localparam int AW   = 6;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          valid_i = 1'b0, we_i = 1'b0, d_i = 1'b0;
  logic [AW-1:0] a_i = '0, dpra_i = '0;
  logic          spo_i = 1'b0, dpo_i = 1'b0, done_i = 1'b0;
  logic [CW-1:0] spo_err_cnt_o, dpo_err_cnt_o;
  logic [AW-1:0] first_err_addr_o;
  logic          first_err_port_o, first_err_vld_o;
  logic [1:0]    status_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lutram_checker #(.A_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .we_i(we_i), .a_i(a_i),
    .dpra_i(dpra_i), .d_i(d_i), .spo_i(spo_i), .dpo_i(dpo_i), .done_i(done_i),
    .spo_err_cnt_o(spo_err_cnt_o), .dpo_err_cnt_o(dpo_err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .first_err_port_o(first_err_port_o),
    .first_err_vld_o(first_err_vld_o), .status_o(status_o)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  bit       m_data  [64];
  bit       m_known [64];
  int       m_spo, m_dpo, m_addr;
  bit       m_fv, m_port, m_done;
  bit [1:0] m_status, m_st_n;
  bit       m_ms, m_md;

  always @(posedge clk) begin
    if (!rst_n_i) begin
      foreach (m_known[i]) m_known[i] = 1'b0;
      m_spo = 0; m_dpo = 0; m_addr = 0; m_fv = 0; m_port = 0; m_done = 0; m_status = 2'b00;
    end else begin
      // Verdict reflects the results held before this edge.
      m_st_n = {m_done, m_done && m_spo == 0 && m_dpo == 0 && !m_fv};
      if (!m_done) begin
        if (valid_i) begin
          m_ms = m_known[a_i]    && (spo_i !== m_data[a_i]);
          m_md = m_known[dpra_i] && (dpo_i !== m_data[dpra_i]);
          if (m_ms && m_spo < CMAX) m_spo++;
          if (m_md && m_dpo < CMAX) m_dpo++;
          if (!m_fv && (m_ms || m_md)) begin
            m_fv = 1; m_port = !m_ms; m_addr = m_ms ? int'(a_i) : int'(dpra_i);
          end
          if (we_i) begin m_data[a_i] = d_i; m_known[a_i] = 1; end
        end
        if (done_i) m_done = 1;
      end
      m_status = m_st_n;
    end
    #1;
    if (chk_en) begin
      check("model spo_cnt", int'(spo_err_cnt_o), m_spo);
      check("model dpo_cnt", int'(dpo_err_cnt_o), m_dpo);
      check("model first_vld", int'(first_err_vld_o), int'(m_fv));
      if (m_fv) begin
        check("model first_addr", int'(first_err_addr_o), m_addr);
        check("model first_port", int'(first_err_port_o), int'(m_port));
      end
      check("model status", int'(status_o), int'(m_status));
    end
  end

  // ---------------- stimulus ----------------
  // Behaviour of a correct RAM64X1D, used to produce legal SPO/DPO.
  bit ram [64];

  // so/dov < 0: drive the correct RAM output; otherwise force that value.
  task automatic step(input bit v, input bit we, input int a, input int dpra, input bit d,
                      input int so, input int dov, input bit dn);
    @(negedge clk);
    valid_i = v; we_i = we; a_i = AW'(a); dpra_i = AW'(dpra); d_i = d; done_i = dn;
    spo_i = (so  < 0) ? ram[a]    : so[0];
    dpo_i = (dov < 0) ? ram[dpra] : dov[0];
    if (v && we) ram[a] = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, -1, -1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " spo_cnt"}, int'(spo_err_cnt_o), 0);
    check({tag, " dpo_cnt"}, int'(dpo_err_cnt_o), 0);
    check({tag, " first_vld"}, int'(first_err_vld_o), 0);
    check({tag, " first_addr"}, int'(first_err_addr_o), 0);
    check({tag, " status"}, int'(status_o), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n_i = 1'b0; valid_i = 0; we_i = 0; done_i = 0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  // clear to 0, write LSB-of-address pattern, read back; fault_addr >= 0 forces SPO=1 there.
  task automatic full_run(input int fault_addr);
    for (int i = 0; i < 64; i++) step(1, 1, i, i, 0, -1, -1, 0);
    for (int i = 0; i < 64; i++) step(1, 1, i, i, i[0], -1, -1, 0);  // DPO expects old value
    for (int i = 0; i < 64; i++) step(1, 0, i, 63 - i, 0, (i == fault_addr) ? 1 : -1, -1, 0);
    step(0, 0, 0, 0, 0, -1, -1, 1);
    idle(2);
  endtask

  initial begin
    foreach (ram[i]) ram[i] = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n_i = 1'b1;
    chk_en  = 1'b1;

    // Unknown locations never produce errors.
    for (int i = 0; i < 64; i++) step(1, 0, i, 63 - i, 0, 1, 1, 0);
    idle(1);
    check("unknown spo_cnt", int'(spo_err_cnt_o), 0);
    check("unknown dpo_cnt", int'(dpo_err_cnt_o), 0);
    check("unknown first_vld", int'(first_err_vld_o), 0);

    // Clean run.
    do_reset();
    full_run(-1);
    check("clean status", int'(status_o), 3);
    check("clean spo_cnt", int'(spo_err_cnt_o), 0);
    check("clean first_vld", int'(first_err_vld_o), 0);

    // Single SPO fault at address 6.
    do_reset();
    full_run(6);
    check("fault spo_cnt", int'(spo_err_cnt_o), 1);
    check("fault dpo_cnt", int'(dpo_err_cnt_o), 0);
    check("fault first_addr", int'(first_err_addr_o), 6);
    check("fault first_port", int'(first_err_port_o), 0);
    check("fault status", int'(status_o), 2);

    // Simultaneous errors, ordering, write/read hazards, valid-low write.
    do_reset();
    step(1, 1, 3, 3, 0, -1, -1, 0);
    step(1, 1, 9, 3, 0, -1, -1, 0);
    step(1, 1, 12, 12, 1, -1, -1, 0);
    step(1, 0, 12, 12, 0, -1, -1, 0);   // write then read: new data expected
    step(0, 1, 3, 3, 1, -1, -1, 0);     // ignored write
    step(1, 0, 3, 9, 0, -1, -1, 0);     // still 0 at 3
    step(1, 0, 3, 9, 0, 1, 1, 0);       // SPO@3 and DPO@9 both wrong
    idle(1);
    check("simul spo_cnt", int'(spo_err_cnt_o), 1);
    check("simul dpo_cnt", int'(dpo_err_cnt_o), 1);
    check("simul first_addr", int'(first_err_addr_o), 3);
    check("simul first_port", int'(first_err_port_o), 0);
    step(1, 0, 9, 12, 0, -1, 0, 0);     // DPO@12 wrong
    idle(1);
    check("later dpo_cnt", int'(dpo_err_cnt_o), 2);
    check("later first_addr", int'(first_err_addr_o), 3);
    check("later first_port", int'(first_err_port_o), 0);

    // Saturation then freeze in DONE.
    do_reset();
    step(1, 1, 0, 0, 0, -1, -1, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 1, -1, 0);
    idle(1);
    check("sat spo_cnt", int'(spo_err_cnt_o), 15);
    step(1, 0, 0, 0, 0, -1, 1, 1);      // DPO error sampled with done_i still counts
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 1, 1, 0);
    idle(1);
    check("frozen spo_cnt", int'(spo_err_cnt_o), 15);
    check("frozen dpo_cnt", int'(dpo_err_cnt_o), 1);
    check("frozen status", int'(status_o), 2);

    // Reset mid-run clears known bits.
    do_reset();
    step(1, 1, 1, 1, 1, -1, -1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 0, -1, 0);
    idle(1);
    check("mid spo_cnt", int'(spo_err_cnt_o), 3);
    do_reset();
    step(1, 0, 1, 1, 0, 0, 0, 0);       // wrong data, but location now unknown
    idle(1);
    check("post-reset spo_cnt", int'(spo_err_cnt_o), 0);
    check("post-reset dpo_cnt", int'(dpo_err_cnt_o), 0);
    check("post-reset first_vld", int'(first_err_vld_o), 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
